reg_file_param: RTL



---
 rtl/reg_file_param.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
//
// General-purpose register file for the single-cycle MIPS datapath.
// Two combinational read ports and one synchronous write port. There is also a
// dedicated link write for jal into LINK_REG, and register 0 always reads zero.
// After reset a clear sequencer zeroes every entry, one per clock. busy stays
// high while it runs, and the datapath must stall during that time.
//
// Optional feature macro: REG_FILE_BYPASS_EN
//   When this macro is defined, a read of the address being written in the
//   current cycle returns the incoming value combinationally. The link value
//   has priority over write_data. When it is not defined, the read returns the
//   stored value until the clock edge.
//
// Ports:
//   clk               system clock, rising-edge active
//   rst               asynchronous reset, active-high
//   read_reg_1/2      read port addresses
//   read_data_1/2     read port data (0 while clearing or for address 0)
//   write_reg         write address
//   write_data        write data
//   signal_reg_write  write enable
//   jal               link-write enable (entry[LINK_REG] <= pc + LINK_OFFSET)
//   pc                current program counter
//   busy              high while the clear sequence runs
//
// Handshake: none. busy is a level stall request. Writes and jal are accepted
// on any rising edge where busy is low. They are ignored while busy is high.
// -----------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              signal_reg_write,
    input  logic              jal,
    input  logic [DATA_W-1:0] pc,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // The state register and the clear counter are the FSM's observable state.
    state_t             state;
    state_t             next_state;
    logic [ADDR_W-1:0]  counter;
    logic [ADDR_W-1:0]  next_counter;

    logic [DATA_W-1:0]  regs [DEPTH];

    logic [DATA_W-1:0]  link_value;
    logic               link_en;
    logic               write_en;

    // pc + LINK_OFFSET wraps modulo 2**DATA_W.
    assign link_value = pc + DATA_W'(LINK_OFFSET);
    assign link_en    = (state == READY) && jal;
    // When both writes target LINK_REG, the link write wins. The ordinary
    // write is dropped in that case.
    assign write_en   = (state == READY) && signal_reg_write && (write_reg != '0)
                        && !(jal && (write_reg == LINK_ADDR));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            counter <= '0;
        end else begin
            state   <= next_state;
            counter <= next_counter;
        end
    end

    always_comb begin
        next_state   = state;
        next_counter = counter;
        busy         = 1'b0;
        case (state)
            CLEAR: begin
                busy         = 1'b1;
                next_counter = counter + 1'b1;
                if (counter == LAST_ADDR) begin
                    next_state   = READY;
                    next_counter = '0;
                end
            end
            READY: begin
                busy = 1'b0;
            end
            default: begin
                next_state = CLEAR;
                busy       = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------- storage
    // The array is not reset. The clear sequencer zeroes it one entry per
    // cycle. rst gates the writes, so an edge that coincides with reset does
    // not disturb any entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[counter] <= '0;
            end else begin
                if (write_en) begin
                    regs[write_reg] <= write_data;
                end
                if (link_en) begin
                    regs[LINK_ADDR] <= link_value;
                end
            end
        end
    end

    // ---------------------------------------------------------------- reads
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        value = '0;
        if (state == READY && addr != '0) begin
            value = regs[addr];
`ifdef REG_FILE_BYPASS_EN
            if (link_en && addr == LINK_ADDR) begin
                value = link_value;
            end else if (write_en && addr == write_reg) begin
                value = write_data;
            end
`endif
        end
        return value;
    endfunction

    always_comb begin
        read_data_1 = '0;
        read_data_2 = '0;
        read_data_1 = read_port(read_reg_1);
        read_data_2 = read_port(read_reg_2);
    end

endmodule
